// File: rtl/pp_pipeline_accel_mul_share_arb_if.sv
// Bundle of the requester, shared-multiplier and result signals of the multiplier-share arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline or the testbench.
interface pp_pipeline_accel_mul_share_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 8,
  parameter int P_WIDTH  = 17
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;

  logic [A_WIDTH-1:0]         mul_din0;
  logic [B_WIDTH-1:0]         mul_din1;
  logic [P_WIDTH-1:0]         mul_dout;

  logic                       res_valid;
  logic                       res_ready;
  logic [P_WIDTH-1:0]         res_data;
  logic [ID_WIDTH-1:0]        res_id;
  logic [15:0]                issue_count;

  modport slave (
    input  req_valid, req_a, req_b, mul_dout, res_ready,
    output req_ready, mul_din0, mul_din1, res_valid, res_data, res_id, issue_count
  );

  modport master (
    output req_valid, req_a, req_b, mul_dout, res_ready,
    input  req_ready, mul_din0, mul_din1, res_valid, res_data, res_id, issue_count
  );
endinterface

// File: rtl/pp_pipeline_accel_mul_share_arb.sv
// Round-robin arbiter that time-shares one combinational signed multiplier among NUM_REQ
// requesters and registers each tagged product into a single-entry valid/ready output stage.
module pp_pipeline_accel_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 8,
  parameter int P_WIDTH  = 17
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  pp_pipeline_accel_mul_share_arb_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                load_en;
  logic                res_valid;

  logic                any_req;
  logic                grant_vld;
  logic [ID_WIDTH-1:0] grant_idx;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [P_WIDTH-1:0]  res_data_q, res_data_d;
  logic [15:0]         cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Output-stage FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values, independent of process order.
    if (!ap_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage FSM: next-state logic
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      EMPTY:   state_d = grant_vld ? FULL : EMPTY;
      FULL:    if (bus.res_ready) state_d = grant_vld ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output-stage FSM: outputs
  always_comb begin
    res_valid = 1'b0;
    load_en   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        res_valid = 1'b0;
        load_en   = 1'b1;
      end
      FULL: begin
        res_valid = 1'b1;
        load_en   = bus.res_ready;
      end
      default: begin
        res_valid = 1'b0;
        load_en   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: the lowest requester above ptr wins; otherwise the
  // search wraps to the lowest valid requester overall.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic                any_hi;
    logic [ID_WIDTH-1:0] idx_hi;
    logic [ID_WIDTH-1:0] idx_lo;
    any_hi  = 1'b0;
    idx_hi  = '0;
    idx_lo  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        any_req = 1'b1;
        idx_lo  = ID_WIDTH'(i);
        if (i > int'(ptr_q)) begin
          any_hi = 1'b1;
          idx_hi = ID_WIDTH'(i);
        end
      end
    end
    grant_idx = any_hi ? idx_hi : idx_lo;
  end

  // Reset forces the grant off so nothing is accepted while the block is held.
  assign grant_vld = load_en & any_req & ap_rst_n;

  // ---------------------------------------------------------------------------
  // One-hot accept and operand steering to the shared multiplier
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = '0;
    bus.mul_din0  = '0;
    bus.mul_din1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (grant_idx == ID_WIDTH'(i))) begin
        bus.req_ready[i] = 1'b1;
        bus.mul_din0     = bus.req_a[i*A_WIDTH +: A_WIDTH];
        bus.mul_din1     = bus.req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result, pointer and issue counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    if (grant_vld) begin
      res_data_d = bus.mul_dout;
      res_id_d   = grant_idx;
      ptr_d      = grant_idx;
      cnt_d      = cnt_q + 16'd1;
    end
  end

  // ptr resets to the last requester so requester 0 has first priority.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
      res_id_q   <= '0;
      res_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.res_valid   = res_valid;
  assign bus.res_data    = res_data_q;
  assign bus.res_id      = res_id_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: doc/pp_pipeline_accel_mul_share_arb.md
Name: pp_pipeline_accel_mul_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one combinational signed multiplier among NUM_REQ requesters inside pp_pipeline_accel.
- The multiplier is the 9s x 8s -> 17 instance; it is driven through the mul_* ports.
- Grants at most one operand pair per cycle and steers it to the multiplier.
- Registers the product with a requester tag into a single-entry output stage with valid/ready backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of res_id; must be >= clog2(NUM_REQ)
A_WIDTH, 9, signed operand A width
B_WIDTH, 8, signed operand B width
P_WIDTH, 17, product width (A_WIDTH+B_WIDTH)

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept, combinational
req_a  in  NUM_REQ*A_WIDTH  packed signed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  packed signed operand B, same packing
mul_din0  out  A_WIDTH  operand A to shared multiplier
mul_din1  out  B_WIDTH  operand B to shared multiplier
mul_dout  in  P_WIDTH  signed product, zero-latency combinational return
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  P_WIDTH  signed product
res_id  out  ID_WIDTH  index of the requester that owns res_data
issue_count  out  16  number of grants issued; wraps modulo 2^16

Behaviour:
- Reset is synchronous, active-low, sampled on ap_clk.
- Reset values: res_valid=0, res_data=0, res_id=0, issue_count=0, last-grant pointer ptr=NUM_REQ-1, so requester 0 has first priority.
- req_ready is combinational and decodes to 0 while ap_rst_n=0.
- Output stage state machine:
  - States: EMPTY (res_valid=0) and FULL (res_valid=1).
  - load_en = EMPTY, or (FULL and res_ready).
- Arbitration is evaluated every cycle when load_en=1:
  - Search req_valid starting at (ptr+1) mod NUM_REQ upward with wrap; the first set bit is g.
  - req_ready = one-hot(g); all zeros if no request is valid or load_en=0.
- Operand steering:
  - Granted cycle: mul_din0=req_a[g], mul_din1=req_b[g], combinational.
  - No grant: mul_din0=0, mul_din1=0.
- Grant cycle, at the next edge:
  - res_data<=mul_dout, res_id<=g, res_valid<=1 (-> FULL).
  - ptr<=g; issue_count<=issue_count+1.
- load_en=1 with no valid request, at the next edge:
  - res_valid<=0 (-> EMPTY); res_data and res_id hold their last value; ptr unchanged.
- FULL and res_ready=0:
  - req_ready=0; res_data, res_id and res_valid hold; ptr holds.
- Pass-through: FULL with res_ready=1 and a pending request means drain and reload in the same cycle. Sustained throughput is 1 result per cycle.
- Latency: request accepted in cycle N -> result visible with res_valid=1 in cycle N+1.
- Arithmetic:
  - Signed two's complement; P_WIDTH=A_WIDTH+B_WIDTH, so there is no overflow or truncation.
  - The extreme case (-256)*(-128)=+32768 fits in 17 bits.
- Requester obligation: req_a/req_b stay stable while req_valid=1 and req_ready=0. The block does not check this.
- A requester may deassert req_valid without being granted; no state is retained for it.
- Reset asserted mid-operation: a held result is discarded (res_valid=0 next cycle), ptr returns to NUM_REQ-1, and issue_count clears.
- res_ready is ignored while EMPTY.

Test Plan:
- Reset: ap_rst_n=0 for 3 cycles with req_valid=4'b1111, res_ready=1 -> req_ready=0, res_valid=0, issue_count=0 in every reset cycle; first post-reset cycle grants requester 0.
- Single request: requester 2 only, req_a=0x100 (-256), req_b=0x80 (-128) -> req_ready=4'b0100 same cycle, mul_din0=0x100, mul_din1=0x80; next cycle res_valid=1, res_data=0x08000 (+32768), res_id=2, issue_count=1.
- Full round-robin: req_valid=4'b1111 held, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, one per cycle, issue_count=8.
- Backpressure: FULL with res_id=1, res_ready=0 for 5 cycles, all requesters valid -> req_ready=0, res_data/res_id stable; res_ready=1 -> same cycle grants requester 2; next cycle res_id=2.
- Skip and wrap: last grant=1, then req_valid=4'b1001 -> grant 3, then 0; res_a=5,b=-3 at requester 3 gives res_data=-15 (0x1FFF1).
- Reset mid-stream: assert ap_rst_n=0 one cycle while FULL (res_id=2) -> next cycle res_valid=0, issue_count=0; after release with req_valid=4'b0101 first grant is 0, then 2.
